// File: rtl/sub16_serial.sv
// -----------------------------------------------------------------------------
// sub16_serial
//
// Bit-serial subtractor: d = a - b - bin, one bit per clock, LSB first,
// through a single full-adder slice fed with a, ~b and a registered carry.
// A start/done handshake sequences one operation of WIDTH+1 edges.
//
// Handshake: start is sampled only while idle (busy=0). The accepting edge
// captures a, b and bin. After WIDTH more edges, done pulses for one cycle
// with d/bout (and ovf) updated. A start presented in the done cycle is
// accepted, so operations can run back to back. Start while busy is ignored.
//
// Ports:
//   clk    - clock, rising edge
//   rst_b  - synchronous active-low reset
//   start  - request a subtraction (sampled only when idle)
//   a, b   - unsigned minuend / subtrahend, WIDTH bits
//   bin    - borrow-in
//   busy   - operation in progress
//   done   - one-cycle pulse, result just updated
//   d      - difference (mod 2^WIDTH), holds the last result
//   bout   - borrow-out, 1 iff a < b + bin
//   ovf    - signed overflow of a - b - bin
//            (port present only when SUB16_SERIAL_OVF_EN is defined)
//
// Optional feature macro: SUB16_SERIAL_OVF_EN
// -----------------------------------------------------------------------------
module sub16_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SUB16_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             nb;
    logic             sum;
    logic             cout;
    logic             last;
    logic [WIDTH-1:0] res_next;

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs decoded from the state register only
    // ---------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        if (state == RUN) busy = 1'b1;
    end

    // ---------------------------------------------------------------
    // Full-adder slice: a + ~b + carry (carry starts as ~bin)
    // ---------------------------------------------------------------
    always_comb begin
        nb       = ~b_sh[0];
        sum      = a_sh[0] ^ nb ^ carry;
        cout     = (a_sh[0] & nb) | (a_sh[0] & carry) | (nb & carry);
        // New bit enters at the MSB; after WIDTH shifts bit 0 sits at LSB.
        res_next = {sum, res_sh[WIDTH-1:1]};
        last     = (cnt == CW'(WIDTH - 1));
    end

    // ---------------------------------------------------------------
    // Datapath and result registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            done   <= 1'b0;
            d      <= '0;
            bout   <= 1'b0;
`ifdef SUB16_SERIAL_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= ~bin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    carry  <= cout;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        d    <= res_next;
                        // Carry out of a + ~b + ~bin is the inverse of borrow.
                        bout <= ~cout;
                        done <= 1'b1;
`ifdef SUB16_SERIAL_OVF_EN
                        // On the MSB edge the carry register holds the
                        // carry into the MSB slice.
                        ovf  <= carry ^ cout;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sub16_serial.md
# sub16_serial

Bit-serial 16-bit subtractor computing `d = a - b - bin`, one bit per clock, through a single full-adder slice and a registered carry. It is the inverse-operation counterpart of the team's registered ripple-carry adder. The block trades latency for area, and a start/done handshake sequences it. It sits in the datapath lab alongside the adder and shares its operand and result conventions.

## Interface
- `WIDTH`, default 16: operand and result width in bits.
- `clk` input, 1 bit: clock; all state updates on its rising edge.
- `rst_b` input, 1 bit: reset, synchronous and active-low.
- `start` input, 1 bit: request a subtraction; sampled only when idle.
- `a` input, WIDTH bits: minuend, unsigned, captured on an accepted `start`.
- `b` input, WIDTH bits: subtrahend, unsigned, captured on an accepted `start`.
- `bin` input, 1 bit: borrow-in, captured on an accepted `start`.
- `busy` output, 1 bit: an operation is in progress.
- `done` output, 1 bit: single-cycle pulse; `d`/`bout` just updated.
- `d` output, WIDTH bits: difference; holds the last result.
- `bout` output, 1 bit: borrow-out; 1 iff `a < b + bin` (unsigned).
- `ovf` output, 1 bit: signed overflow; present only with `SUB16_SERIAL_OVF_EN`.

## Operation
- Arithmetic: `a + ~b + ~bin` computed LSB first. Carry register initialised to `~bin`, then `bout = ~carry_out(MSB)`. The result is taken modulo 2^WIDTH.
- Internal state:
  - shift registers for `a`, `b` and the partial result;
  - 1-bit carry;
  - bit counter, `$clog2(WIDTH)+1` bits.
- FSM, two states:
  - **IDLE**: `start=1` captures `a`, `b`, `bin`, clears the counter, sets the carry to `~bin`, and moves to RUN.
  - **RUN**: each edge does the following.
    - Feeds `a_sh[0]`, `~b_sh[0]` and the carry to the full adder.
    - Shifts the sum into the result MSB and shifts the operands right.
    - Updates the carry and increments the counter.
  - RUN to IDLE: on the edge processing bit WIDTH-1, the final result goes to `d` and `~carry` goes to `bout`, `done` is set, and the FSM returns to IDLE.
- `start` while in RUN: ignored; operands are not recaptured.
- `start` in the cycle `done=1`: accepted, because the FSM is already IDLE. Back-to-back operations therefore run with no idle gap.
- `d` and `bout` change only on completion. The partial result stays internal.
- Reset (`rst_b=0` at an edge), whether in IDLE or mid-RUN:
  - state goes to IDLE; `busy=0`, `done=0`, `d=0`, `bout=0`, `ovf=0`;
  - any operation in flight is discarded with no `done`.
- Reset has priority over `start`.

## Timing
- All outputs are registered; none is combinational from any input.
- Call E0 the edge where `start` is accepted.
  - `busy=1` after E0.
  - Edges E1..EWIDTH process bits 0..WIDTH-1.
  - After EWIDTH: `busy=0`, `done=1`, and `d`/`bout` are valid.
  - After EWIDTH+1: `done=0` unless a new operation completes.
- Latency from `start` sampled to `done` high is WIDTH+1 edges: 17 for WIDTH=16.
- Throughput is one result per WIDTH+1 cycles.
- `busy` and `done` are never high together.

## Configuration
- Macro `SUB16_SERIAL_OVF_EN`.
- **Defined**:
  - A 1-bit register captures the carry into the MSB slice.
  - `ovf = carry_in(MSB) ^ carry_out(MSB)` is registered with `d`. It means two's-complement overflow of `a - b - bin`.
  - `ovf` holds until the next completion and resets to 0.
- **Undefined**: the `ovf` port and its register are absent, and all other behaviour is identical.

## Test plan
- `a=0x1234`, `b=0x0234`, `bin=0`, `start` pulse: `done` after 17 edges with `d=0x1000`, `bout=0`, and `busy` high for exactly 16 cycles.
- `a=0x0000`, `b=0x0001`, `bin=0`: `d=0xFFFF`, `bout=1`. Then `a=0x0005`, `b=0x0005`, `bin=1`: `d=0xFFFF`, `bout=1`.
- Start `a=0xFFFF`, `b=0x0001`, then at cycle 5 assert `start` with `a=0`, `b=0`: the second request is ignored and the result is `d=0xFFFE`, `bout=0`. `start` with `a=3`, `b=1` in the `done` cycle gives `d=0x0002` 17 edges later.
- `rst_b=0` for one edge at cycle 8 of an operation: all outputs 0, no `done` pulse, and a following `start` with `a=7`, `b=2` yields `d=5`.
- With `SUB16_SERIAL_OVF_EN`:
  - `a=0x8000`, `b=0x0001`: `d=0x7FFF`, `ovf=1`, `bout=0`.
  - `a=0x0001`, `b=0x0002`: `d=0xFFFF`, `ovf=0`, `bout=1`.
